// File: rtl/md_sequencer.sv
// Multiply/divide sequencer owning HI/LO with fixed multi-cycle busy latency.
// Build option MD_DIVZERO_KEEP_EN: divide-by-zero leaves HI/LO untouched.
module md_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic [3:0]  MD_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] E_Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MD_out
);

   localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W   = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
   localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       hi_q, hi_d, lo_q, lo_d;
   logic [31:0]       res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic              is_mul, is_div, b_zero, commit;
   logic [63:0]       prod_s, prod_u;
   logic [31:0]       q_s, r_s, q_u, r_u;
   logic [31:0]       calc_hi, calc_lo;
`ifdef MD_DIVZERO_KEEP_EN
   logic              keep_q, keep_d;
`endif

   assign is_mul = (MD_op == 4'd1) || (MD_op == 4'd2);
   assign is_div = (MD_op == 4'd3) || (MD_op == 4'd4);
   assign b_zero = (B == '0);

   assign Busy   = (state_q == RUN);
   assign Start  = (is_mul || is_div) && !Busy && !Req;
   assign E_Busy = {31'b0, Start | Busy};
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MD_out = (MD_op == 4'd5) ? hi_q : (MD_op == 4'd6) ? lo_q : '0;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'b0, A} * {32'b0, B};

   // -2^31 / -1 overflows; pin it to the wrapped quotient with zero remainder.
   always_comb begin
      q_s = '0;
      r_s = '0;
      q_u = '0;
      r_u = '0;
      if (!b_zero) begin
         q_u = A / B;
         r_u = A % B;
         if (A == 32'h8000_0000 && B == '1) begin
            q_s = A;
         end else begin
            q_s = 32'($signed(A) / $signed(B));
            r_s = 32'($signed(A) % $signed(B));
         end
      end
   end

   always_comb begin
      calc_hi = '0;
      calc_lo = '0;
      case (MD_op)
         4'd1:    {calc_hi, calc_lo} = prod_s;
         4'd2:    {calc_hi, calc_lo} = prod_u;
         4'd3:    {calc_hi, calc_lo} = b_zero ? {A, 32'hFFFF_FFFF} : {r_s, q_s};
         4'd4:    {calc_hi, calc_lo} = b_zero ? {A, 32'hFFFF_FFFF} : {r_u, q_u};
         default: {calc_hi, calc_lo} = '0;
      endcase
   end

`ifdef MD_DIVZERO_KEEP_EN
   assign commit = !keep_q;
`else
   assign commit = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
`ifdef MD_DIVZERO_KEEP_EN
      keep_d   = keep_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               res_hi_d = calc_hi;
               res_lo_d = calc_lo;
               cnt_d    = is_mul ? MULT_LD : DIV_LD;
               state_d  = RUN;
`ifdef MD_DIVZERO_KEEP_EN
               keep_d   = is_div && b_zero;
`endif
            end else if (!Req) begin
               if (MD_op == 4'd7) hi_d = A;
               if (MD_op == 4'd8) lo_d = A;
            end
         end
         RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (commit) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
`ifdef MD_DIVZERO_KEEP_EN
         keep_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
`ifdef MD_DIVZERO_KEEP_EN
         keep_q   <= keep_d;
`endif
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed plan vectors plus random ops vs. an arithmetic model.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        Req;
   logic [3:0]  MD_op;
   logic [31:0] A, B;
   logic        Start, Busy;
   logic [31:0] E_Busy, HI, LO, MD_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .Req(Req), .MD_op(MD_op), .A(A), .B(B),
      .Start(Start), .Busy(Busy), .E_Busy(E_Busy), .HI(HI), .LO(LO), .MD_out(MD_out)
   );

   always #5 clk = ~clk;

   // Returns {HI, LO} as the architecture defines each op.
   function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, b, hi, lo);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if ((op == 4'd3 || op == 4'd4) && b == 32'd0) begin
`ifdef MD_DIVZERO_KEEP_EN
         return {hi, lo};
`else
         return {a, 32'hFFFF_FFFF};
`endif
      end
      case (op)
         4'd1: return 64'(sa * sb);
         4'd2: return ua * ub;
         4'd3: begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: return {32'(ua % ub), 32'(ua / ub)};
         default: return {hi, lo};
      endcase
   endfunction

   function automatic int lat(input logic [3:0] op);
      return (op <= 4'd2) ? 5 : 10;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, b, input logic req);
      MD_op = op; A = a; B = b; Req = req;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      MD_op = '0; A = '0; B = '0; Req = 1'b0;
      #12;
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0) begin
         errors++; $display("FAIL reset_hilo got HI=%h LO=%h exp 0/0", HI, LO);
      end
      reset = 1'b1;
      tick();
      drive(4'd5, '0, '0, 1'b0);
      checks++;
      if (Busy !== 1'b0 || E_Busy !== 32'd0) begin
         errors++; $display("FAIL reset_idle got Busy=%b E_Busy=%h exp 0/0", Busy, E_Busy);
      end
      checks++;
      if (MD_out !== 32'd0) begin
         errors++; $display("FAIL reset_mfhi got %h exp 0", MD_out);
      end
      tick();
   endtask

   // Runs directed plan vectors then random ops back to back; each next start issues in cycle N+1.
   task automatic test_arith(input int n);
      logic [3:0]  t_op[4];
      logic [31:0] t_a[4], t_b[4], t_hi[4], t_lo[4];
      logic [3:0]  op;
      logic [31:0] a, b, eh, el;
      logic [63:0] r;
      t_op = '{4'd1, 4'd2, 4'd3, 4'd4};
      t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7};
      t_b  = '{32'd2, 32'd2, 32'd2, 32'd2};
      t_hi = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1};
      t_lo = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd3};
      for (int i = 0; i < n; i++) begin
         if (i < 4) begin
            op = t_op[i]; a = t_a[i]; b = t_b[i]; eh = t_hi[i]; el = t_lo[i];
         end else begin
            op = 4'($urandom_range(1, 4));
            a  = (i == 4) ? 32'h8000_0000 : $urandom;
            b  = (i == 4) ? 32'hFFFF_FFFF : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom);
            if (i == 4) op = 4'd3;
            r = ref_md(op, a, b, m_hi, m_lo);
            eh = r[63:32]; el = r[31:0];
         end
         drive(op, a, b, 1'b0);
         checks++;
         if (Start !== 1'b1 || E_Busy !== 32'd1) begin
            errors++; $display("FAIL start op=%0d got Start=%b E_Busy=%h exp 1/1", op, Start, E_Busy);
         end
         tick();
         for (int c = 1; c <= lat(op); c++) begin
            drive(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            checks++;
            if (Busy !== 1'b1 || Start !== 1'b0 || E_Busy !== 32'd1) begin
               errors++; $display("FAIL busy op=%0d cyc=%0d got Busy=%b Start=%b E_Busy=%h exp 1/0/1", op, c, Busy, Start, E_Busy);
            end
            tick();
         end
         drive(4'd0, '0, '0, 1'b0);
         checks++;
         if (Busy !== 1'b0 || HI !== eh || LO !== el) begin
            errors++; $display("FAIL result op=%0d a=%h b=%h got Busy=%b HI=%h LO=%h exp 0 HI=%h LO=%h", op, a, b, Busy, HI, LO, eh, el);
         end
         m_hi = eh; m_lo = el;
      end
      tick();
   endtask

   task automatic test_req();
      drive(4'd1, 32'd9, 32'd9, 1'b1);
      checks++;
      if (Start !== 1'b0) begin
         errors++; $display("FAIL req_start got %b exp 0", Start);
      end
      tick();
      drive(4'd7, 32'd5, '0, 1'b1);
      checks++;
      if (Busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
         errors++; $display("FAIL req_mult got Busy=%b HI=%h LO=%h exp 0 %h %h", Busy, HI, LO, m_hi, m_lo);
      end
      tick();
      drive(4'd7, 32'd5, '0, 1'b0);
      checks++;
      if (HI !== m_hi) begin
         errors++; $display("FAIL req_mthi got HI=%h exp %h", HI, m_hi);
      end
      tick();
      m_hi = 32'd5;
      drive(4'd5, '0, '0, 1'b0);
      checks++;
      if (HI !== 32'd5 || MD_out !== 32'd5) begin
         errors++; $display("FAIL mthi got HI=%h MD_out=%h exp 5", HI, MD_out);
      end
      a_mtlo: begin
         logic [31:0] v;
         v = $urandom;
         drive(4'd8, v, '0, 1'b0);
         tick();
         m_lo = v;
         drive(4'd6, '0, '0, 1'b0);
         checks++;
         if (MD_out !== v || LO !== v) begin
            errors++; $display("FAIL mtlo got MD_out=%h LO=%h exp %h", MD_out, LO, v);
         end
      end
      drive(4'($urandom_range(9, 15)), 32'd3, 32'd3, 1'b0);
      checks++;
      if (Start !== 1'b0 || MD_out !== 32'd0 || E_Busy !== 32'd0) begin
         errors++; $display("FAIL op_none got Start=%b MD_out=%h E_Busy=%h exp 0/0/0", Start, MD_out, E_Busy);
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      drive(4'd7, 32'h1111_2222, '0, 1'b0);
      tick();
      m_hi = 32'h1111_2222;
      drive(4'd1, 32'd3, 32'd7, 1'b0);
      tick();
      drive(4'd0, '0, '0, 1'b0);
      tick();
      drive(4'd0, '0, '0, 1'b1);
      tick();
      drive(4'd8, 32'hDEAD_BEEF, '0, 1'b0);
      checks++;
      if (Start !== 1'b0) begin
         errors++; $display("FAIL ign_mtlo_start got %b exp 0", Start);
      end
      tick();
      drive(4'd1, 32'd100, 32'd100, 1'b0);
      checks++;
      if (Start !== 1'b0 || LO !== m_lo) begin
         errors++; $display("FAIL ign_mult got Start=%b LO=%h exp 0 %h", Start, LO, m_lo);
      end
      tick();
      drive(4'd5, '0, '0, 1'b0);
      checks++;
      if (Busy !== 1'b1 || MD_out !== m_hi) begin
         errors++; $display("FAIL ign_cyc5 got Busy=%b MD_out=%h exp 1 %h", Busy, MD_out, m_hi);
      end
      tick();
      drive(4'd0, '0, '0, 1'b0);
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd21) begin
         errors++; $display("FAIL ign_result got Busy=%b HI=%h LO=%h exp 0 0 15", Busy, HI, LO);
      end
      m_hi = 32'd0; m_lo = 32'd21;
      tick();
   endtask

   task automatic test_divzero();
      logic [63:0] r;
      for (int k = 0; k < 2; k++) begin
         logic [3:0]  op;
         logic [31:0] a;
         op = (k == 0) ? 4'd3 : 4'd4;
         a  = (k == 0) ? 32'h1234_5678 : 32'hF000_000F;
         drive(4'd7, 32'hAAAA_0001 + k, '0, 1'b0); tick();
         drive(4'd8, 32'h5555_0002 + k, '0, 1'b0); tick();
         m_hi = 32'hAAAA_0001 + k; m_lo = 32'h5555_0002 + k;
         r = ref_md(op, a, 32'd0, m_hi, m_lo);
         drive(op, a, 32'd0, 1'b0);
         tick();
         for (int c = 1; c <= 10; c++) begin
            drive(4'd0, '0, '0, 1'b0);
            if (c == 10) begin
               checks++;
               if (Busy !== 1'b1) begin
                  errors++; $display("FAIL dz_busy op=%0d cyc10 got %b exp 1", op, Busy);
               end
            end
            tick();
         end
         drive(4'd0, '0, '0, 1'b0);
         checks++;
         if (Busy !== 1'b0 || HI !== r[63:32] || LO !== r[31:0]) begin
            errors++; $display("FAIL dz_result op=%0d got Busy=%b HI=%h LO=%h exp 0 %h %h", op, Busy, HI, LO, r[63:32], r[31:0]);
         end
         m_hi = r[63:32]; m_lo = r[31:0];
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive(4'd7, 32'h77, '0, 1'b0); tick();
      drive(4'd8, 32'h88, '0, 1'b0); tick();
      drive(4'd3, 32'd100, 32'd7, 1'b0); tick();
      for (int c = 1; c < 4; c++) begin
         drive(4'd0, '0, '0, 1'b0); tick();
      end
      drive(4'd0, '0, '0, 1'b0);
      reset = 1'b0;
      #1;
      checks++;
      if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0 || E_Busy !== 32'd0) begin
         errors++; $display("FAIL rst_mid got HI=%h LO=%h Busy=%b E_Busy=%h exp 0", HI, LO, Busy, E_Busy);
      end
      tick(); tick();
      #3;
      reset = 1'b1;
      m_hi = '0; m_lo = '0;
      tick();
      for (int c = 0; c < 12; c++) begin
         drive(4'd0, '0, '0, 1'b0);
         checks++;
         if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL rst_after cyc=%0d got Busy=%b HI=%h LO=%h exp 0", c, Busy, HI, LO);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_arith(40);
      test_req();
      test_busy_ignore();
      test_divzero();
      test_reset_mid();
      test_arith(12);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
